// File: rtl/dma_seq_pkg.sv
// Shared types and constants for the DMA command sequencer slice.
package dma_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CHECK,
    S_ISSUE,
    S_DRAIN,
    S_FINISH
  } state_e;

  localparam int unsigned CMD_START = 0;
  localparam int unsigned ADDR_W    = 32;

  // True when addr sits on a burst_bytes boundary (burst_bytes is a power of two).
  function automatic logic addr_aligned(input logic [ADDR_W-1:0] addr,
                                        input int unsigned       burst_bytes);
    logic [ADDR_W-1:0] mask;
    mask = ADDR_W'(burst_bytes - 1);
    return (addr & mask) == '0;
  endfunction

endpackage

// File: rtl/dma_outstanding_ctr.sv
// Saturating up/down count of write bursts issued but not yet completed.
module dma_outstanding_ctr
#(
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic ACLK,
  input  logic ARESETN,
  input  logic inc_i,
  input  logic dec_i,
  output logic full_o,
  output logic empty_o
);

  localparam int unsigned CW = $clog2(MAX_OUTSTANDING + 1);

  logic [CW-1:0] count_q, count_d;
  logic          up, dn;

  assign full_o  = (count_q == CW'(MAX_OUTSTANDING));
  assign empty_o = (count_q == '0);

  always_comb begin
    // A completion at zero is dropped, so stray pulses after a reset cannot underflow.
    dn      = dec_i && !empty_o;
    up      = inc_i && (!full_o || dn);
    count_d = count_q;
    if (up && !dn) begin
      count_d = count_q + CW'(1);
    end else if (dn && !up) begin
      count_d = count_q - CW'(1);
    end
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/dma_cmd_sequencer.sv
// Splits one configured transfer into burst read/write requests, bounds
// in-flight write bursts and reports completion to the config block.
module dma_cmd_sequencer
  import dma_seq_pkg::*;
#(
  parameter  int unsigned BURST_BYTES     = 128,
  parameter  int unsigned MAX_OUTSTANDING = 4,
  localparam int unsigned BW              = $clog2(BURST_BYTES) + 1
) (
  input  logic          ACLK,
  input  logic          ARESETN,
  input  logic          CFG_VALID,
  output logic          CFG_READY,
  input  logic [31:0]   CFG_CMD,
  input  logic [31:0]   CFG_SRC,
  input  logic [31:0]   CFG_DEST,
  input  logic [31:0]   CFG_LEN,
  output logic          RD_REQ_VALID,
  input  logic          RD_REQ_READY,
  output logic [31:0]   RD_REQ_ADDR,
  output logic [BW-1:0] RD_REQ_BYTES,
  output logic          WR_REQ_VALID,
  input  logic          WR_REQ_READY,
  output logic [31:0]   WR_REQ_ADDR,
  output logic [BW-1:0] WR_REQ_BYTES,
  input  logic          WR_DONE,
  output logic          BUSY,
  output logic          DONE,
  output logic          ERR
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] src_q, src_d;
  logic [ADDR_W-1:0] dest_q, dest_d;
  logic [ADDR_W-1:0] rem_q, rem_d;
  logic              start_q, start_d;
  logic              rd_taken_q, rd_taken_d;
  logic              wr_taken_q, wr_taken_d;
  logic              err_q, err_d;

  logic [BW-1:0]     cur_bytes;
  logic              rd_fire, wr_fire;
  logic              ctr_full, ctr_empty;
  logic              unused_cmd;

  assign unused_cmd = ^CFG_CMD;

  assign cur_bytes = (rem_q < ADDR_W'(BURST_BYTES)) ? rem_q[BW-1:0] : BW'(BURST_BYTES);

  assign CFG_READY    = (state_q == S_IDLE);
  assign BUSY         = (state_q != S_IDLE);
  assign DONE         = (state_q == S_FINISH);
  assign ERR          = err_q;
  assign RD_REQ_VALID = (state_q == S_ISSUE) && !rd_taken_q && !ctr_full;
  assign WR_REQ_VALID = (state_q == S_ISSUE) && !wr_taken_q && !ctr_full;
  assign RD_REQ_ADDR  = src_q;
  assign WR_REQ_ADDR  = dest_q;
  assign RD_REQ_BYTES = cur_bytes;
  assign WR_REQ_BYTES = cur_bytes;
  assign rd_fire      = RD_REQ_VALID && RD_REQ_READY;
  assign wr_fire      = WR_REQ_VALID && WR_REQ_READY;

  dma_outstanding_ctr #(
    .MAX_OUTSTANDING (MAX_OUTSTANDING)
  ) u_outstanding (
    .ACLK    (ACLK),
    .ARESETN (ARESETN),
    .inc_i   (wr_fire),
    .dec_i   (WR_DONE),
    .full_o  (ctr_full),
    .empty_o (ctr_empty)
  );

  always_comb begin
    state_d    = state_q;
    src_d      = src_q;
    dest_d     = dest_q;
    rem_d      = rem_q;
    start_d    = start_q;
    rd_taken_d = rd_taken_q;
    wr_taken_d = wr_taken_q;
    err_d      = err_q;
    case (state_q)
      S_IDLE: begin
        if (CFG_VALID) begin
          src_d   = CFG_SRC;
          dest_d  = CFG_DEST;
          rem_d   = CFG_LEN;
          start_d = CFG_CMD[CMD_START];
          err_d   = 1'b0;
          state_d = S_CHECK;
        end
      end
      S_CHECK: begin
        if (!start_q || rem_q == '0) begin
          state_d = S_FINISH;
        end else if (!addr_aligned(src_q, BURST_BYTES) || !addr_aligned(dest_q, BURST_BYTES)) begin
          err_d   = 1'b1;
          state_d = S_FINISH;
        end else begin
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        // A burst retires only once both sides have been handshaken, in any order.
        rd_taken_d = rd_taken_q || rd_fire;
        wr_taken_d = wr_taken_q || wr_fire;
        if (rd_taken_d && wr_taken_d) begin
          src_d      = src_q + ADDR_W'(cur_bytes);
          dest_d     = dest_q + ADDR_W'(cur_bytes);
          rem_d      = rem_q - ADDR_W'(cur_bytes);
          rd_taken_d = 1'b0;
          wr_taken_d = 1'b0;
          if (rem_d == '0) begin
            state_d = S_DRAIN;
          end
        end
      end
      S_DRAIN: begin
        if (ctr_empty) begin
          state_d = S_FINISH;
        end
      end
      S_FINISH: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (!ARESETN) begin
      state_q    <= S_IDLE;
      src_q      <= '0;
      dest_q     <= '0;
      rem_q      <= '0;
      start_q    <= 1'b0;
      rd_taken_q <= 1'b0;
      wr_taken_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      src_q      <= src_d;
      dest_q     <= dest_d;
      rem_q      <= rem_d;
      start_q    <= start_d;
      rd_taken_q <= rd_taken_d;
      wr_taken_q <= wr_taken_d;
      err_q      <= err_d;
    end
  end

endmodule

// File: tb/tb_dma_cmd_sequencer.sv
// Scoreboard bench for dma_cmd_sequencer: expected bursts and completions are
// queued per command by a reference model and popped by a cycle monitor.
module tb_dma_cmd_sequencer;

  localparam int unsigned BB = 128;
  localparam int          MO = 2;
  localparam int unsigned BW = $clog2(BB) + 1;

  typedef struct {
    logic [31:0] addr;
    int unsigned bytes;
  } req_t;

  logic          ACLK = 1'b0;
  logic          ARESETN = 1'b0;
  logic          CFG_VALID = 1'b0;
  logic          CFG_READY;
  logic [31:0]   CFG_CMD = '0, CFG_SRC = '0, CFG_DEST = '0, CFG_LEN = '0;
  logic          RD_REQ_VALID, WR_REQ_VALID;
  logic          RD_REQ_READY = 1'b1, WR_REQ_READY = 1'b1;
  logic [31:0]   RD_REQ_ADDR, WR_REQ_ADDR;
  logic [BW-1:0] RD_REQ_BYTES, WR_REQ_BYTES;
  logic          WR_DONE = 1'b0;
  logic          BUSY, DONE, ERR;

  req_t rd_exp[$];
  req_t wr_exp[$];
  bit   done_exp[$];

  int checks = 0;
  int errors = 0;
  int outstanding_m = 0;
  int done_credit = 0;
  int release_n = 0;
  int extra_pulses = 0;
  int wr_seen = 0;
  bit withhold = 1'b0;
  bit rand_ready = 1'b0;
  bit manual = 1'b0;

  logic        prv_rd_stall = 1'b0, prv_wr_stall = 1'b0;
  logic [31:0] prv_rd_addr, prv_wr_addr, prv_rd_bytes, prv_wr_bytes;

  always #5 ACLK = ~ACLK;

  dma_cmd_sequencer #(
    .BURST_BYTES     (BB),
    .MAX_OUTSTANDING (MO)
  ) dut (
    .ACLK         (ACLK),
    .ARESETN      (ARESETN),
    .CFG_VALID    (CFG_VALID),
    .CFG_READY    (CFG_READY),
    .CFG_CMD      (CFG_CMD),
    .CFG_SRC      (CFG_SRC),
    .CFG_DEST     (CFG_DEST),
    .CFG_LEN      (CFG_LEN),
    .RD_REQ_VALID (RD_REQ_VALID),
    .RD_REQ_READY (RD_REQ_READY),
    .RD_REQ_ADDR  (RD_REQ_ADDR),
    .RD_REQ_BYTES (RD_REQ_BYTES),
    .WR_REQ_VALID (WR_REQ_VALID),
    .WR_REQ_READY (WR_REQ_READY),
    .WR_REQ_ADDR  (WR_REQ_ADDR),
    .WR_REQ_BYTES (WR_REQ_BYTES),
    .WR_DONE      (WR_DONE),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .ERR          (ERR)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  // Reference model: a transfer is len bytes cut into BB-sized pieces, last one short.
  task automatic model_push(input logic [31:0] cmd, input logic [31:0] src,
                            input logic [31:0] dest, input logic [31:0] len);
    bit             start, err;
    logic [31:0]    a, b;
    longint unsigned r;
    int unsigned    n;
    start = cmd[0];
    err   = start && (len != 0) && (((src % BB) != 0) || ((dest % BB) != 0));
    a = src;
    b = dest;
    r = len;
    if (start && len != 0 && !err) begin
      while (r > 0) begin
        n = (r > BB) ? BB : int'(r);
        rd_exp.push_back('{addr: a, bytes: n});
        wr_exp.push_back('{addr: b, bytes: n});
        a = a + n;
        b = b + n;
        r = r - n;
      end
    end
    done_exp.push_back(err);
  endtask

  task automatic flush_model();
    rd_exp.delete();
    wr_exp.delete();
    done_exp.delete();
    done_credit = 0;
    release_n = 0;
  endtask

  task automatic do_reset();
    ARESETN = 1'b0;
    CFG_VALID = 1'b0;
    @(posedge ACLK); #1;
    flush_model();
    @(posedge ACLK); #1;
    ARESETN = 1'b1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_cfg_ready"}, 32'(CFG_READY), 1);
    chk({tag, "_rd_valid"}, 32'(RD_REQ_VALID), 0);
    chk({tag, "_wr_valid"}, 32'(WR_REQ_VALID), 0);
    chk({tag, "_busy"}, 32'(BUSY), 0);
    chk({tag, "_done"}, 32'(DONE), 0);
    chk({tag, "_err"}, 32'(ERR), 0);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the handshake edge.
  task automatic send_cmd(input logic [31:0] cmd, input logic [31:0] src,
                          input logic [31:0] dest, input logic [31:0] len);
    int n;
    n = 0;
    while (!CFG_READY && n < 200) begin
      @(posedge ACLK); #1;
      n++;
    end
    if (!CFG_READY) begin
      fail_now("cfg_ready_timeout");
      do_reset();
    end
    model_push(cmd, src, dest, len);
    CFG_CMD = cmd; CFG_SRC = src; CFG_DEST = dest; CFG_LEN = len;
    CFG_VALID = 1'b1;
    @(posedge ACLK); #1;
    CFG_VALID = 1'b0;
  endtask

  task automatic wait_idle(input int budget, input string name);
    for (int i = 0; i < budget; i++) begin
      if (done_exp.size() == 0 && CFG_READY) return;
      @(posedge ACLK); #1;
    end
    fail_now({name, "_completion_timeout"});
    do_reset();
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge ACLK); #1;
    end
  endtask

  // Response driver: request readies and WR_DONE pulses owed for accepted writes.
  always @(posedge ACLK) begin
    #1;
    if (!manual) begin
      RD_REQ_READY = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      WR_REQ_READY = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
    end
    if (extra_pulses > 0) begin
      WR_DONE = 1'b1;
      extra_pulses--;
    end else if (done_credit > 0 && (release_n > 0 || (!withhold && $urandom_range(0, 2) == 0))) begin
      WR_DONE = 1'b1;
      done_credit--;
      if (release_n > 0) release_n--;
    end else begin
      WR_DONE = 1'b0;
    end
  end

  // Monitor: pops the scoreboard on each handshake and completion.
  always @(negedge ACLK) begin
    req_t e;
    bit   exp_err, dec;
    if (!ARESETN) begin
      outstanding_m = 0;
      prv_rd_stall = 1'b0;
      prv_wr_stall = 1'b0;
    end else begin
      if (RD_REQ_VALID || WR_REQ_VALID)
        chk("outstanding_bound", 32'(outstanding_m < MO), 1);
      if (prv_rd_stall && RD_REQ_VALID) begin
        chk("rd_addr_stable", RD_REQ_ADDR, prv_rd_addr);
        chk("rd_bytes_stable", 32'(RD_REQ_BYTES), prv_rd_bytes);
      end
      if (prv_wr_stall && WR_REQ_VALID) begin
        chk("wr_addr_stable", WR_REQ_ADDR, prv_wr_addr);
        chk("wr_bytes_stable", 32'(WR_REQ_BYTES), prv_wr_bytes);
      end
      if (DONE) begin
        if (done_exp.size() == 0) begin
          fail_now("done_unexpected");
        end else begin
          exp_err = done_exp.pop_front();
          chk("done_err", 32'(ERR), 32'(exp_err));
          chk("done_busy", 32'(BUSY), 1);
          chk("done_rd_all_issued", rd_exp.size(), 0);
          chk("done_wr_all_issued", wr_exp.size(), 0);
          chk("done_drained", outstanding_m, 0);
        end
      end
      if (RD_REQ_VALID && RD_REQ_READY) begin
        if (rd_exp.size() == 0) begin
          fail_now("rd_req_unexpected");
        end else begin
          e = rd_exp.pop_front();
          chk("rd_addr", RD_REQ_ADDR, e.addr);
          chk("rd_bytes", 32'(RD_REQ_BYTES), e.bytes);
        end
      end
      dec = WR_DONE && (outstanding_m > 0);
      if (WR_REQ_VALID && WR_REQ_READY) begin
        wr_seen++;
        outstanding_m++;
        done_credit++;
        if (wr_exp.size() == 0) begin
          fail_now("wr_req_unexpected");
        end else begin
          e = wr_exp.pop_front();
          chk("wr_addr", WR_REQ_ADDR, e.addr);
          chk("wr_bytes", 32'(WR_REQ_BYTES), e.bytes);
        end
      end
      if (dec) outstanding_m--;
      prv_rd_stall = RD_REQ_VALID && !RD_REQ_READY;
      prv_wr_stall = WR_REQ_VALID && !WR_REQ_READY;
      prv_rd_addr  = RD_REQ_ADDR;
      prv_wr_addr  = WR_REQ_ADDR;
      prv_rd_bytes = 32'(RD_REQ_BYTES);
      prv_wr_bytes = 32'(WR_REQ_BYTES);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] c, s, d, l;
    int n;

    ARESETN = 1'b0;
    wait_cycles(3);
    chk_reset_vals("reset");
    ARESETN = 1'b1;
    wait_cycles(1);

    // 512 bytes, readies high: four aligned bursts, first VALID two cycles after handshake.
    send_cmd(32'h1, 32'h1000, 32'h8000, 32'd512);
    chk("t1_check_cycle_no_valid", 32'(RD_REQ_VALID), 0);
    chk("t1_check_cycle_busy", 32'(BUSY), 1);
    wait_cycles(1);
    chk("t1_first_rd_valid", 32'(RD_REQ_VALID), 1);
    chk("t1_first_wr_valid", 32'(WR_REQ_VALID), 1);
    chk("t1_first_rd_addr", RD_REQ_ADDR, 32'h1000);
    wait_idle(400, "t1");

    // Short trailing burst.
    send_cmd(32'h1, 32'h1000, 32'h8000, 32'd200);
    wait_idle(400, "t2");

    // Outstanding limit with completions withheld.
    withhold = 1'b1;
    wr_seen = 0;
    send_cmd(32'h1, 32'h2000, 32'h9000, 32'd512);
    wait_cycles(12);
    chk("hold_wr_count", wr_seen, 2);
    chk("hold_rd_valid_low", 32'(RD_REQ_VALID), 0);
    chk("hold_wr_valid_low", 32'(WR_REQ_VALID), 0);
    release_n = 1;
    wait_cycles(12);
    chk("release_one_wr_count", wr_seen, 3);
    chk("release_one_wr_valid_low", 32'(WR_REQ_VALID), 0);
    withhold = 1'b0;
    wait_idle(400, "t3");

    // Misaligned source: error, DONE at t+2, sticky ERR until next handshake.
    send_cmd(32'h1, 32'h1004, 32'h8000, 32'd256);
    chk("misalign_check_done_low", 32'(DONE), 0);
    wait_cycles(1);
    chk("misalign_done_t2", 32'(DONE), 1);
    chk("misalign_err", 32'(ERR), 1);
    chk("misalign_no_rd_valid", 32'(RD_REQ_VALID), 0);
    wait_cycles(1);
    chk("misalign_ready_t3", 32'(CFG_READY), 1);
    chk("misalign_err_sticky", 32'(ERR), 1);
    send_cmd(32'h0, 32'h0, 32'h0, 32'd64);
    chk("noop_err_cleared", 32'(ERR), 0);
    wait_cycles(1);
    chk("noop_done_t2", 32'(DONE), 1);
    wait_cycles(1);
    chk("noop_ready_t3", 32'(CFG_READY), 1);
    wait_idle(50, "t4");

    // Read side stalled while write side accepts immediately.
    manual = 1'b1;
    RD_REQ_READY = 1'b0;
    WR_REQ_READY = 1'b1;
    send_cmd(32'h1, 32'h5000, 32'hB000, 32'd256);
    wait_cycles(1);
    chk("rdstall_c0_wr_valid", 32'(WR_REQ_VALID), 1);
    wait_cycles(1);
    chk("rdstall_c1_wr_dropped", 32'(WR_REQ_VALID), 0);
    chk("rdstall_c1_rd_held", 32'(RD_REQ_VALID), 1);
    wait_cycles(1);
    chk("rdstall_c2_wr_dropped", 32'(WR_REQ_VALID), 0);
    RD_REQ_READY = 1'b1;
    wait_cycles(1);
    chk("rdstall_next_wr_valid", 32'(WR_REQ_VALID), 1);
    chk("rdstall_next_wr_addr", WR_REQ_ADDR, 32'hB080);
    manual = 1'b0;
    wait_idle(400, "t5");

    // Reset with two bursts outstanding, then stray completions, then a fresh command.
    withhold = 1'b1;
    send_cmd(32'h1, 32'h3000, 32'hC000, 32'd512);
    n = 0;
    while (outstanding_m != MO && n < 40) begin
      wait_cycles(1);
      n++;
    end
    if (outstanding_m != MO) fail_now("rst_reach_two_outstanding");
    wait_cycles(1);
    ARESETN = 1'b0;
    wait_cycles(1);
    chk_reset_vals("midrst");
    flush_model();
    wait_cycles(1);
    ARESETN = 1'b1;
    withhold = 1'b0;
    extra_pulses = 3;
    wait_cycles(6);
    chk("post_rst_idle", 32'(CFG_READY), 1);
    send_cmd(32'h1, 32'h4000, 32'hA000, 32'd384);
    wait_idle(400, "t6");

    // Randomized commands with random readies and completion timing.
    rand_ready = 1'b1;
    for (int k = 0; k < 30; k++) begin
      c = $urandom;
      c[0] = ($urandom_range(0, 7) != 0);
      s = $urandom & ~32'(BB - 1);
      d = $urandom & ~32'(BB - 1);
      if ($urandom_range(0, 9) == 0) s[2] = 1'b1;
      if ($urandom_range(0, 9) == 0) d[3] = 1'b1;
      if (k % 7 == 3) d = 32'hFFFF_FF80;
      l = ($urandom_range(0, 7) == 0) ? 32'd0 : 32'($urandom_range(1, 700));
      send_cmd(c, s, d, l);
      wait_idle(3000, "rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
